// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Hazard and sequencing controller for the five-stage MIPS pipeline.
//   Each cycle it decides whether the PC and IF/ID hold, and whether IF/ID and
//   ID/EX are flushed. It covers load-use, taken branches resolved in EX, jumps
//   decoded in ID, and a multi-cycle multiply/divide unit (MDU). It also keeps
//   saturating performance counters for stall cycles and flush events.
//
// Parameters
//   MDU_LATENCY  cycles the MDU stays busy after a start is accepted (>=1)
//   CNT_W        width of the MDU countdown, 2**CNT_W > MDU_LATENCY
//   PERF_W       width of each performance counter
//
// Ports
//   clk, reset              rising-edge clock, asynchronous active-high reset
//   MemRead_EX, rt_EX       load in EX and its destination register
//   rs_ID, rt_ID            source register fields of the ID instruction
//   UsesRs_ID, UsesRt_ID    ID instruction actually reads rs / rt
//   Branch_EX, BranchTaken_EX  branch in EX and its resolved condition
//   Jump_ID                 j/jal/jr/jalr decoded in ID
//   MduStart_ID, MduRead_ID mult/div or mfhi/mflo in ID
//   hold_PC, hold_IFID      hold controls (combinational)
//   flush_IFID, flush_IDEX  bubble-insert controls (combinational)
//   mdu_start               MDU start accepted this cycle
//   mdu_busy, mdu_done      MDU countdown active / registered completion pulse
//   stall_cycles            saturating count of cycles with hold_PC=1
//   flush_events            saturating count of cycles with flush_IFID=1
module pipeline_hazard_ctrl #(
  parameter int MDU_LATENCY = 32,
  parameter int CNT_W       = 6,
  parameter int PERF_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead_EX,
  input  logic [4:0]        rt_EX,
  input  logic [4:0]        rs_ID,
  input  logic [4:0]        rt_ID,
  input  logic              UsesRs_ID,
  input  logic              UsesRt_ID,
  input  logic              Branch_EX,
  input  logic              BranchTaken_EX,
  input  logic              Jump_ID,
  input  logic              MduStart_ID,
  input  logic              MduRead_ID,
  output logic              hold_PC,
  output logic              hold_IFID,
  output logic              flush_IFID,
  output logic              flush_IDEX,
  output logic              mdu_start,
  output logic              mdu_busy,
  output logic              mdu_done,
  output logic [PERF_W-1:0] stall_cycles,
  output logic [PERF_W-1:0] flush_events
);

  typedef enum logic {RUN, BUSY} state_t;

  localparam logic [CNT_W-1:0] LAT = CNT_W'(MDU_LATENCY);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic load_use;
  logic br_flush;
  logic mdu_stall;
  logic stall;

  // Counters stop at all-ones; the check happens before the increment.
  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
    return (v == {PERF_W{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Hazard detection (combinational)
  // $zero never creates a dependency, hence the rt_EX != 0 term.
  assign load_use  = MemRead_EX && (rt_EX != 5'd0) &&
                     ((UsesRs_ID && (rs_ID == rt_EX)) ||
                      (UsesRt_ID && (rt_ID == rt_EX)));
  assign br_flush  = Branch_EX && BranchTaken_EX;
  assign mdu_busy  = (state == BUSY);
  assign mdu_stall = mdu_busy && (MduRead_ID || MduStart_ID);
  assign stall     = load_use || mdu_stall;

  // A start squashed by a taken branch or held by a stall is not accepted;
  // a held start is retried once the stall clears.
  assign mdu_start = MduStart_ID && !br_flush && !stall;

  // Taken branch outranks a stall: the stalled instruction is on the wrong
  // path anyway, so it is flushed instead of held.
  always_comb begin
    hold_PC    = 1'b0;
    hold_IFID  = 1'b0;
    flush_IFID = 1'b0;
    flush_IDEX = 1'b0;
    if (br_flush) begin
      flush_IFID = 1'b1;
      flush_IDEX = 1'b1;
    end else if (stall) begin
      hold_PC    = 1'b1;
      hold_IFID  = 1'b1;
      flush_IDEX = 1'b1;
    end else if (Jump_ID) begin
      flush_IFID = 1'b1;
    end
  end

  // MDU sequencing FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= RUN;
      cnt      <= '0;
      mdu_done <= 1'b0;
    end else begin
      mdu_done <= 1'b0;
      case (state)
        RUN: begin
          if (mdu_start) begin
            state <= BUSY;
            cnt   <= LAT;
          end
        end
        BUSY: begin
          if (cnt == ONE) begin
            state    <= RUN;
            cnt      <= '0;
            mdu_done <= 1'b1;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Performance counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (hold_PC)    stall_cycles <= sat_inc(stall_cycles);
      if (flush_IFID) flush_events <= sat_inc(flush_events);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
module tb_pipeline_hazard_ctrl;

  localparam int LAT    = 4;
  localparam int CNT_W  = 3;
  localparam int PERF_W = 4;
  localparam int SAT    = 15;

  logic              clk = 1'b0;
  logic              reset;
  logic              MemRead_EX;
  logic [4:0]        rt_EX, rs_ID, rt_ID;
  logic              UsesRs_ID, UsesRt_ID;
  logic              Branch_EX, BranchTaken_EX, Jump_ID;
  logic              MduStart_ID, MduRead_ID;
  logic              hold_PC, hold_IFID, flush_IFID, flush_IDEX;
  logic              mdu_start, mdu_busy, mdu_done;
  logic [PERF_W-1:0] stall_cycles, flush_events;

  pipeline_hazard_ctrl #(.MDU_LATENCY(LAT), .CNT_W(CNT_W), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset(reset),
    .MemRead_EX(MemRead_EX), .rt_EX(rt_EX), .rs_ID(rs_ID), .rt_ID(rt_ID),
    .UsesRs_ID(UsesRs_ID), .UsesRt_ID(UsesRt_ID),
    .Branch_EX(Branch_EX), .BranchTaken_EX(BranchTaken_EX), .Jump_ID(Jump_ID),
    .MduStart_ID(MduStart_ID), .MduRead_ID(MduRead_ID),
    .hold_PC(hold_PC), .hold_IFID(hold_IFID),
    .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
    .mdu_start(mdu_start), .mdu_busy(mdu_busy), .mdu_done(mdu_done),
    .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  // ctl order: hold_PC hold_IFID flush_IFID flush_IDEX mdu_start mdu_busy mdu_done
  typedef struct {
    logic [6:0] ctl;
    int         sc;
    int         fe;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // reference model state
  int   m_left = 0;
  bit   m_done = 0;
  int   m_sc   = 0;
  int   m_fe   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_left = 0; m_done = 0; m_sc = 0; m_fe = 0;
  endtask

  // Drive one cycle of ID/EX information, predict outputs, compare, advance model.
  task automatic step(input logic mr, input logic [4:0] rte, input logic [4:0] rsi,
                      input logic [4:0] rti, input logic urs, input logic urt,
                      input logic br, input logic bt, input logic jmp,
                      input logic mst, input logic mrd, input string tag);
    exp_t e, got;
    bit lu, brf, busy, st, hp, hi, fi, fx, start, nd;
    @(negedge clk);
    MemRead_EX = mr; rt_EX = rte; rs_ID = rsi; rt_ID = rti;
    UsesRs_ID = urs; UsesRt_ID = urt; Branch_EX = br; BranchTaken_EX = bt;
    Jump_ID = jmp; MduStart_ID = mst; MduRead_ID = mrd;
    lu   = mr && rte != 0 && ((urs && rsi == rte) || (urt && rti == rte));
    brf  = br && bt;
    busy = (m_left > 0);
    st   = lu || (busy && (mrd || mst));
    hp = 0; hi = 0; fi = 0; fx = 0;
    if (brf) begin fi = 1; fx = 1; end
    else if (st) begin hp = 1; hi = 1; fx = 1; end
    else if (jmp) fi = 1;
    start = mst && !brf && !st;
    e.ctl = {hp, hi, fi, fx, start, busy, m_done};
    e.sc  = m_sc;
    e.fe  = m_fe;
    sb.push_back(e);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check({tag, "_ctl"}, {25'd0, hold_PC, hold_IFID, flush_IFID, flush_IDEX,
                            mdu_start, mdu_busy, mdu_done}, {25'd0, got.ctl});
      check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'(got.sc));
      check({tag, "_flush_events"}, 32'(flush_events), 32'(got.fe));
    end
    @(posedge clk);
    nd = (m_left == 1);
    if (m_left > 0) m_left--;
    if (start) m_left = LAT;
    m_done = nd;
    if (hp && m_sc < SAT) m_sc++;
    if (fi && m_fe < SAT) m_fe++;
  endtask

  task automatic idle(input string tag);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    MemRead_EX = 0; rt_EX = 0; rs_ID = 0; rt_ID = 0; UsesRs_ID = 0; UsesRt_ID = 0;
    Branch_EX = 0; BranchTaken_EX = 0; Jump_ID = 0; MduStart_ID = 0; MduRead_ID = 0;
    #1;
    check("rst_outputs", {21'd0, hold_PC, hold_IFID, flush_IFID, flush_IDEX, mdu_start,
                          mdu_busy, mdu_done, stall_cycles}, 32'd0);
    check("rst_flush_events", 32'(flush_events), 32'd0);
    @(posedge clk);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    idle("idle0");

    // load-use on rs: one stall cycle, then the load has moved on
    step(1, 5, 5, 0, 1, 0, 0, 0, 0, 0, 0, "lu_rs");
    step(0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, "lu_after");
    idle("lu_idle");
    check("lu_stall_count", 32'(stall_cycles), 32'd1);
    // $zero and unused-operand cases do not stall; rt operand does
    step(1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, "lu_zero");
    step(1, 5, 5, 0, 0, 0, 0, 0, 0, 0, 0, "lu_nouse");
    step(1, 9, 3, 9, 1, 1, 0, 0, 0, 0, 0, "lu_rt");
    step(1, 9, 9, 3, 0, 1, 0, 0, 0, 0, 0, "lu_rt_nomatch");
    step(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, "br_not_taken");

    // priority: branch beats load-use, jump alone flushes IF/ID only
    do_reset();
    step(1, 5, 5, 0, 1, 0, 1, 1, 1, 0, 0, "prio_br_lu");
    idle("prio_idle");
    check("prio_flush_count", 32'(flush_events), 32'd1);
    check("prio_no_stall", 32'(stall_cycles), 32'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, "jump");
    step(1, 5, 5, 0, 1, 0, 0, 0, 1, 0, 0, "lu_over_jump");

    // MDU: start, mflo stalled while busy, proceeds when busy drops
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "mdu_start");
    idle("mdu_c1");
    for (int i = 2; i <= 5; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, $sformatf("mflo_c%0d", i));
    idle("mdu_c6");
    check("mdu_stall_count", 32'(stall_cycles), 32'd3);

    // back-to-back starts: second start waits out the busy window
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, $sformatf("b2b_%0d", i));
    for (int i = 0; i < 5; i++) idle($sformatf("b2b_drain_%0d", i));

    // start squashed by taken branch; start deferred by load-use
    step(0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, "start_br");
    idle("start_br_after");
    step(1, 7, 7, 0, 1, 0, 0, 0, 0, 1, 0, "start_lu");
    step(0, 0, 7, 0, 1, 0, 0, 0, 0, 1, 0, "start_lu_retry");
    for (int i = 0; i < 5; i++) idle($sformatf("start_lu_drain_%0d", i));

    // reset mid-countdown aborts immediately with no done pulse
    do_reset();
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, "abort_start");
    idle("abort_c1");
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    check("abort_busy", 32'(mdu_busy), 32'd0);
    check("abort_cnt", 32'(stall_cycles), 32'd0);
    @(posedge clk);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) idle($sformatf("abort_after_%0d", i));

    // saturation of both counters
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 4, 4, 0, 1, 0, 0, 0, 0, 0, 0, $sformatf("sat_%0d", i));
    for (int i = 0; i < 18; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, $sformatf("satj_%0d", i));
    idle("sat_idle");
    check("sat_stall", 32'(stall_cycles), 32'd15);
    check("sat_flush", 32'(flush_events), 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the five-stage MIPS pipeline. Each cycle it decides whether the PC and IF/ID register hold, and whether IF/ID and ID/EX are flushed. Hazards covered: load-use, taken branches resolved in EX, jumps decoded in ID, and a multi-cycle multiply/divide unit (MDU). It also tracks MDU busy time and keeps saturating stall/flush performance counters.

## Interface
- MDU_LATENCY, 32, cycles the MDU is busy after a start is accepted (≥1)
- CNT_W, 6, width of MDU countdown; must satisfy 2^CNT_W > MDU_LATENCY
- PERF_W, 16, width of each performance counter

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- MemRead_EX  in  1  instruction in EX is a load
- rt_EX  in  5  load destination register in EX
- rs_ID  in  5  rs field of instruction in ID
- rt_ID  in  5  rt field of instruction in ID
- UsesRs_ID  in  1  ID instruction reads rs
- UsesRt_ID  in  1  ID instruction reads rt
- Branch_EX  in  1  branch instruction in EX
- BranchTaken_EX  in  1  branch condition true in EX
- Jump_ID  in  1  j/jal/jr/jalr decoded in ID
- MduStart_ID  in  1  mult/multu/div/divu in ID
- MduRead_ID  in  1  mfhi/mflo in ID
- hold_PC  out  1  PC keeps its value
- hold_IFID  out  1  IF/ID keeps its value
- flush_IFID  out  1  IF/ID loads a bubble
- flush_IDEX  out  1  ID/EX loads a bubble (drives flush_IDEX of ID/EX)
- mdu_start  out  1  one-cycle strobe: MDU start accepted this cycle
- mdu_busy  out  1  MDU countdown nonzero
- mdu_done  out  1  registered one-cycle pulse on the first cycle after countdown reaches 0
- stall_cycles  out  PERF_W  saturating count of cycles with hold_PC=1
- flush_events  out  PERF_W  saturating count of cycles with flush_IFID=1

## Operation
- The hazard terms are combinational:
  - load_use = MemRead_EX & (rt_EX≠0) & ((UsesRs_ID & rs_ID==rt_EX) | (UsesRt_ID & rt_ID==rt_EX))
  - br_flush = Branch_EX & BranchTaken_EX
  - mdu_stall = mdu_busy & (MduRead_ID | MduStart_ID)
  - stall = load_use | mdu_stall
- Priority of actions, highest first:
  - br_flush: flush_IFID=1, flush_IDEX=1, holds=0. This overrides stall and jump.
  - stall: hold_PC=1, hold_IFID=1, flush_IDEX=1, flush_IFID=0.
  - Jump_ID: flush_IFID=1 only.
  - Otherwise all four outputs are 0.
- mdu_start = MduStart_ID & ~br_flush & ~stall.
- FSM states:
  - RUN (cnt=0): on mdu_start, go to BUSY with cnt←MDU_LATENCY.
  - BUSY: cnt decrements each cycle. When cnt==1, go to RUN (cnt←0) and set mdu_done←1 for the next cycle.
  - A start cannot be accepted in BUSY; it is stalled by mdu_stall.
- mdu_busy = (state==BUSY).
- Performance counters:
  - stall_cycles increments on each clock edge where hold_PC=1.
  - flush_events increments on each edge where flush_IFID=1.
  - Both hold at 2^PERF_W−1.

## Timing
- While reset is asserted: state=RUN, cnt=0, mdu_done=0, and both counters=0.
- Control outputs are combinational from inputs and state, so with idle inputs every output is 0 during reset.
- Reset asserted mid-BUSY aborts the countdown immediately; mdu_done does not pulse.
- Load-use stall lasts exactly 1 cycle: the bubble moves the load to MEM, so load_use drops the next cycle.
- MDU timing: start accepted at edge E0 gives mdu_busy high for cycles E0+1 … E0+MDU_LATENCY, and mdu_done high in cycle E0+MDU_LATENCY+1.
  - An mfhi/mflo in ID during busy cycles is stalled. It proceeds in the first cycle with busy low.
- A start in ID in the same cycle as br_flush is squashed: no mdu_start, no state change.
- A start with a concurrent load_use is deferred; it is accepted once the stall clears.
- A taken branch during a stall flushes rather than holds, and stall_cycles does not increment that cycle.
- Counter increments and the FSM update share the same edge. Saturation is checked before the increment, so there is no wrap.

## Test plan
- Load-use: lw $5 in EX (MemRead_EX=1, rt_EX=5), add using rs_ID=5 in ID -> one cycle of hold_PC=hold_IFID=flush_IDEX=1, then all 0; stall_cycles=1.
- rt_EX=0 with rs_ID=0, MemRead_EX=1 -> no stall. Same hazard with UsesRs_ID=0 -> no stall.
- Priority: br_flush and load_use in the same cycle -> flush_IFID=flush_IDEX=1, hold_PC=0; flush_events=1. Jump_ID alone -> only flush_IFID=1.
- MDU, MDU_LATENCY=4: start at edge 0 -> mdu_busy in cycles 1–4, mdu_done in cycle 5 only; mflo in ID at cycle 2 -> stalled through cycle 4, proceeds in cycle 5.
- Back-to-back starts: second mult in ID during BUSY -> stalled until busy drops, then mdu_start pulses. Start coincident with br_flush -> no mdu_start, stays RUN.
- Reset asserted at cycle 2 of an MDU countdown -> mdu_busy=0 immediately, no mdu_done. Counters cleared. Forcing PERF_W=4 with 20 stall cycles -> stall_cycles=15.
